alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_pkg.sv | 10 +
 rtl/alu_issue_ctrl_if.sv | 26 ++
 rtl/alu_issue_ctrl_decode.sv | 35 +++
 rtl/alu_issue_ctrl.sv | 74 +++++++
 tb/tb_alu_issue_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: ALU op codes, funct codes, aluop classes and FSM state type shared by the issue controller
package alu_issue_ctrl_pkg;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110,
                         OP_SLT = 4'b0111, OP_SGE = 4'b1000, OP_SLL = 4'b1001, OP_SRL = 4'b1010,
                         OP_NOR = 4'b1100;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_ADD = 6'h20, F_SUB = 6'h22,
                         F_AND = 6'h24, F_OR = 6'h25, F_NOR = 6'h27, F_SLT = 6'h2A;
  localparam logic [1:0] AC_ADD = 2'b00, AC_SUB = 2'b01, AC_RTYPE = 2'b10, AC_SGE = 2'b11;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request (valid/ready, aluop, funct, shamt, src1/src2), ALU drive/return and response (valid/ready, result, zero, ovf_trap, illegal) bundle; slave = controller, master = requester/ALU side
interface alu_issue_ctrl_if;
  logic        req_valid_i, req_ready_o;
  logic [1:0]  req_aluop_i;
  logic [5:0]  req_funct_i;
  logic [4:0]  req_shamt_i;
  logic [31:0] req_src1_i, req_src2_i;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_src1_o, alu_src2_o, alu_result_i;
  logic        alu_zero_i, alu_overflow_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        rsp_zero_o, rsp_ovf_trap_o, rsp_illegal_o;
  modport slave (
    input  req_valid_i, req_aluop_i, req_funct_i, req_shamt_i, req_src1_i, req_src2_i,
           alu_result_i, alu_zero_i, alu_overflow_i, rsp_ready_i,
    output req_ready_o, alu_op_o, alu_src1_o, alu_src2_o,
           rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_ovf_trap_o, rsp_illegal_o
  );
  modport master (
    output req_valid_i, req_aluop_i, req_funct_i, req_shamt_i, req_src1_i, req_src2_i,
           alu_result_i, alu_zero_i, alu_overflow_i, rsp_ready_i,
    input  req_ready_o, alu_op_o, alu_src1_o, alu_src2_o,
           rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_ovf_trap_o, rsp_illegal_o
  );
endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// alu_op_decode: combinational aluop/funct -> ALU op code, legal flag, overflow-trap enable (shift functs legal only with ALU_ISSUE_SHIFT_EN)
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] op,
  output logic       legal,
  output logic       ovf_check
);
  always_comb begin
    op = OP_ADD;
    legal = 1'b1;
    ovf_check = aluop == AC_ADD || (aluop == AC_RTYPE && funct == F_ADD);
    case (aluop)
      AC_SUB: op = OP_SUB;
      AC_SGE: op = OP_SGE;
      AC_RTYPE:
        case (funct)
          F_AND: op = OP_AND;
          F_OR:  op = OP_OR;
          F_ADD: op = OP_ADD;
          F_SUB: op = OP_SUB;
          F_SLT: op = OP_SLT;
          F_NOR: op = OP_NOR;
`ifdef ALU_ISSUE_SHIFT_EN
          F_SLL: op = OP_SLL;
          F_SRL: op = OP_SRL;
`endif
          default: legal = 1'b0;
        endcase
      default: op = OP_ADD;
    endcase
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: one-in-flight ALU issue FSM (clk_i, async rst_i, bus = slave request/ALU/response bundle); ALU_LAT settle cycles; shifts via ALU_ISSUE_SHIFT_EN
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_issue_ctrl_if.slave bus
);
  state_t state, state_nx;
  logic [3:0] cnt, dec_op;
  logic [31:0] src1_nx, src2_nx;
  logic dec_legal, dec_ovf, ovf_chk, accept;
  alu_op_decode u_dec (
    .aluop(bus.req_aluop_i),
    .funct(bus.req_funct_i),
    .op(dec_op),
    .legal(dec_legal),
    .ovf_check(dec_ovf)
  );
`ifdef ALU_ISSUE_SHIFT_EN
  logic shift;
  assign shift = dec_op == OP_SLL || dec_op == OP_SRL;
  assign src1_nx = shift ? bus.req_src2_i : bus.req_src1_i;
  assign src2_nx = shift ? {27'b0, bus.req_shamt_i} : bus.req_src2_i;
`else
  assign src1_nx = bus.req_src1_i;
  assign src2_nx = bus.req_src2_i;
`endif
  assign bus.req_ready_o = state == IDLE;
  assign bus.rsp_valid_o = state == RESP;
  assign accept = bus.req_valid_i && state == IDLE;
  always_comb begin
    state_nx = accept ? (dec_legal ? EXEC : RESP) :
               (state == EXEC && cnt == 4'd1) ? RESP :
               (state == RESP && bus.rsp_ready_i) ? IDLE : state;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  // Illegal requests leave the ALU drive untouched so the previous op stays on the ALU.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt <= '0;
      ovf_chk <= 1'b0;
      bus.alu_op_o <= '0;
      bus.alu_src1_o <= '0;
      bus.alu_src2_o <= '0;
      bus.rsp_result_o <= '0;
      bus.rsp_zero_o <= 1'b0;
      bus.rsp_ovf_trap_o <= 1'b0;
      bus.rsp_illegal_o <= 1'b0;
    end else if (accept) begin
      ovf_chk <= dec_ovf;
      bus.rsp_illegal_o <= !dec_legal;
      bus.rsp_result_o <= '0;
      bus.rsp_zero_o <= 1'b0;
      bus.rsp_ovf_trap_o <= 1'b0;
      if (dec_legal) begin
        cnt <= 4'(ALU_LAT);
        bus.alu_op_o <= dec_op;
        bus.alu_src1_o <= src1_nx;
        bus.alu_src2_o <= src2_nx;
      end
    end else if (state == EXEC) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        bus.rsp_result_o <= bus.alu_result_i;
        bus.rsp_zero_o <= bus.alu_zero_i;
        bus.rsp_ovf_trap_o <= ovf_chk & bus.alu_overflow_i;
      end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed self-checking bench with a behavioural ALU for ALU_LAT=1 and ALU_LAT=4 instances
module tb_alu_issue_ctrl;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic force_ovf = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [32:0] m1, m4;
  always #5 clk_i = ~clk_i;
  alu_issue_ctrl_if b1 ();
  alu_issue_ctrl_if b4 ();
  alu_issue_ctrl #(.ALU_LAT(1)) u1 (.clk_i(clk_i), .rst_i(rst_i), .bus(b1));
  alu_issue_ctrl #(.ALU_LAT(4)) u4 (.clk_i(clk_i), .rst_i(rst_i), .bus(b4));
  function automatic logic [32:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic v;
    r = '0;
    v = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0110: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b0111: r = {31'b0, $signed(a) < $signed(b)};
      4'b1000: r = {31'b0, $signed(a) >= $signed(b)};
      4'b1001: r = a << b[4:0];
      4'b1010: r = a >> b[4:0];
      4'b1100: r = ~(a | b);
      default: r = '0;
    endcase
    return {v, r};
  endfunction
  assign m1 = alu(b1.alu_op_o, b1.alu_src1_o, b1.alu_src2_o);
  assign b1.alu_result_i = m1[31:0];
  assign b1.alu_overflow_i = m1[32] | force_ovf;
  assign b1.alu_zero_i = m1[31:0] == 32'd0;
  assign m4 = alu(b4.alu_op_o, b4.alu_src1_o, b4.alu_src2_o);
  assign b4.alu_result_i = m4[31:0];
  assign b4.alu_overflow_i = m4[32] | force_ovf;
  assign b4.alu_zero_i = m4[31:0] == 32'd0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic req1(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b);
    b1.req_aluop_i = op;
    b1.req_funct_i = f;
    b1.req_shamt_i = sh;
    b1.req_src1_i = a;
    b1.req_src2_i = b;
    b1.req_valid_i = 1'b1;
    tick();
    b1.req_valid_i = 1'b0;
  endtask
  initial begin
    bit seen;
    b1.req_valid_i = 0; b1.req_aluop_i = 0; b1.req_funct_i = 0; b1.req_shamt_i = 0;
    b1.req_src1_i = 0; b1.req_src2_i = 0; b1.rsp_ready_i = 1;
    b4.req_valid_i = 0; b4.req_aluop_i = 0; b4.req_funct_i = 0; b4.req_shamt_i = 0;
    b4.req_src1_i = 0; b4.req_src2_i = 0; b4.rsp_ready_i = 0;
    repeat (2) tick();
    rst_i = 1'b0;
    chk("rst_req_ready", 32'(b1.req_ready_o), 1);
    chk("rst_rsp_valid", 32'(b1.rsp_valid_o), 0);
    chk("rst_alu_op", 32'(b1.alu_op_o), 0);
    chk("rst_src1", b1.alu_src1_o, 0);
    chk("rst_result", b1.rsp_result_o, 0);
    chk("rst_illegal", 32'(b1.rsp_illegal_o), 0);
    req1(2'b10, 6'h20, 5'd0, 32'd5, 32'd7);
    chk("add_op", 32'(b1.alu_op_o), 32'b0010);
    chk("add_src1", b1.alu_src1_o, 5);
    chk("add_src2", b1.alu_src2_o, 7);
    chk("add_busy", 32'(b1.req_ready_o), 0);
    chk("add_early", 32'(b1.rsp_valid_o), 0);
    tick();
    chk("add_valid", 32'(b1.rsp_valid_o), 1);
    chk("add_result", b1.rsp_result_o, 12);
    chk("add_zero", 32'(b1.rsp_zero_o), 0);
    chk("add_trap", 32'(b1.rsp_ovf_trap_o), 0);
    chk("add_illegal", 32'(b1.rsp_illegal_o), 0);
    tick();
    chk("add_done_valid", 32'(b1.rsp_valid_o), 0);
    chk("add_done_ready", 32'(b1.req_ready_o), 1);
    req1(2'b00, 6'h3F, 5'd0, 32'h7FFF_FFFF, 32'd1);
    tick();
    chk("ovf_result", b1.rsp_result_o, 32'h8000_0000);
    chk("ovf_trap", 32'(b1.rsp_ovf_trap_o), 1);
    tick();
    force_ovf = 1'b1;
    req1(2'b10, 6'h2A, 5'd0, 32'h7FFF_FFFF, 32'd1);
    chk("slt_op", 32'(b1.alu_op_o), 32'b0111);
    tick();
    chk("slt_result", b1.rsp_result_o, 0);
    chk("slt_zero", 32'(b1.rsp_zero_o), 1);
    chk("slt_trap", 32'(b1.rsp_ovf_trap_o), 0);
    tick();
    req1(2'b01, 6'h00, 5'd0, 32'd10, 32'd3);
    chk("sub_op", 32'(b1.alu_op_o), 32'b0110);
    tick();
    chk("sub_result", b1.rsp_result_o, 7);
    chk("sub_trap", 32'(b1.rsp_ovf_trap_o), 0);
    tick();
    force_ovf = 1'b0;
    req1(2'b11, 6'h00, 5'd0, 32'd10, 32'd3);
    chk("sge_op", 32'(b1.alu_op_o), 32'b1000);
    tick();
    chk("sge_result", b1.rsp_result_o, 1);
    tick();
    req1(2'b10, 6'h27, 5'd0, 32'hF0F0_0000, 32'h0000_0F0F);
    chk("nor_op", 32'(b1.alu_op_o), 32'b1100);
    tick();
    chk("nor_result", b1.rsp_result_o, 32'h0F0F_F0F0);
    tick();
    b1.rsp_ready_i = 1'b0;
    req1(2'b10, 6'h3F, 5'd0, 32'd1, 32'd2);
    chk("ill_valid", 32'(b1.rsp_valid_o), 1);
    chk("ill_flag", 32'(b1.rsp_illegal_o), 1);
    chk("ill_result", b1.rsp_result_o, 0);
    chk("ill_zero", 32'(b1.rsp_zero_o), 0);
    chk("ill_alu_op_held", 32'(b1.alu_op_o), 32'b1100);
    chk("ill_src1_held", b1.alu_src1_o, 32'hF0F0_0000);
    tick();
    chk("ill_hold_valid", 32'(b1.rsp_valid_o), 1);
    chk("ill_hold_flag", 32'(b1.rsp_illegal_o), 1);
    b1.rsp_ready_i = 1'b1;
    tick();
    chk("ill_done_valid", 32'(b1.rsp_valid_o), 0);
    req1(2'b10, 6'h00, 5'd4, 32'd99, 32'd1);
`ifdef ALU_ISSUE_SHIFT_EN
    chk("sll_op", 32'(b1.alu_op_o), 32'b1001);
    chk("sll_src1", b1.alu_src1_o, 1);
    chk("sll_src2", b1.alu_src2_o, 4);
    tick();
    chk("sll_result", b1.rsp_result_o, 16);
    chk("sll_illegal", 32'(b1.rsp_illegal_o), 0);
`else
    chk("sll_valid", 32'(b1.rsp_valid_o), 1);
    chk("sll_illegal", 32'(b1.rsp_illegal_o), 1);
    chk("sll_result", b1.rsp_result_o, 0);
`endif
    tick();
    b4.req_aluop_i = 2'b00;
    b4.req_src1_i = 32'd100;
    b4.req_src2_i = 32'd23;
    b4.req_valid_i = 1'b1;
    tick();
    b4.req_valid_i = 1'b0;
    repeat (3) tick();
    chk("lat4_early", 32'(b4.rsp_valid_o), 0);
    chk("lat4_busy", 32'(b4.req_ready_o), 0);
    tick();
    chk("lat4_valid", 32'(b4.rsp_valid_o), 1);
    chk("lat4_result", b4.rsp_result_o, 123);
    b4.req_aluop_i = 2'b01;
    b4.req_src1_i = 32'd9;
    b4.req_src2_i = 32'd9;
    b4.req_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lat4_hold_valid", 32'(b4.rsp_valid_o), 1);
      chk("lat4_hold_result", b4.rsp_result_o, 123);
      chk("lat4_hold_busy", 32'(b4.req_ready_o), 0);
      chk("lat4_hold_src1", b4.alu_src1_o, 100);
    end
    b4.rsp_ready_i = 1'b1;
    tick();
    b4.req_valid_i = 1'b0;
    chk("lat4_done_valid", 32'(b4.rsp_valid_o), 0);
    chk("lat4_done_ready", 32'(b4.req_ready_o), 1);
    chk("lat4_no_bypass", 32'(b4.alu_op_o), 32'b0010);
    b4.req_aluop_i = 2'b00;
    b4.req_src1_i = 32'd1;
    b4.req_src2_i = 32'd1;
    b4.req_valid_i = 1'b1;
    tick();
    b4.req_valid_i = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
    chk("rst_mid_op", 32'(b4.alu_op_o), 0);
    chk("rst_mid_src1", b4.alu_src1_o, 0);
    chk("rst_mid_src2", b4.alu_src2_o, 0);
    chk("rst_mid_result", b4.rsp_result_o, 0);
    chk("rst_mid_valid", 32'(b4.rsp_valid_o), 0);
    chk("rst_mid_ready", 32'(b4.req_ready_o), 1);
    tick();
    rst_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= b4.rsp_valid_o;
    end
    chk("rst_no_rsp", 32'(seen), 0);
    chk("rst_after_ready", 32'(b4.req_ready_o), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
